// File: rtl/gpio_stream_pkg.sv
// Shared register-map constants and the STATUS word layout for gpio_stream_ctrl.
package gpio_stream_pkg;

  localparam int OFF_DATA   = 0;
  localparam int OFF_STATUS = 1;
  localparam int OFF_CTRL   = 2;
  localparam int OFF_DROPS  = 3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // Field order matches the bit positions above when zero-extended to the bus width.
  typedef struct packed {
    logic [7:0] count;
    logic [4:0] rsvd;
    logic       ovf;
    logic       full;
    logic       empty;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count, flush and a zeroed head when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle; flush voids both.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpio_stream_ctrl.sv
// Memory-mapped multi-channel GPIO output controller: bus stores are queued per
// channel and drained to the consumer over a valid/ready handshake.
module gpio_stream_ctrl
  import gpio_stream_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                GPIO_W    = 8,
  parameter int                CHANNELS  = 2,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0000_0400
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         hit,
  output logic [CHANNELS*GPIO_W-1:0]   gpio_data,
  output logic [CHANNELS-1:0]          gpio_valid,
  input  logic [CHANNELS-1:0]          gpio_ready,
  output logic                         irq
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [ADDR_W-1:0] offset;
  logic [1:0]        reg_sel;
  logic [CH_W-1:0]   ch_sel;
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] irq_en_q;
  logic [DATA_W-1:0] ch_rd [CHANNELS];
  logic              unused_wr_data;

  // Addresses below the base wrap to a huge offset, so the lower-bound test is explicit.
  assign offset  = addr - BASE_ADDR;
  assign hit     = (addr >= BASE_ADDR) && (offset < ADDR_W'(4 * CHANNELS));
  assign reg_sel = offset[1:0];
  assign ch_sel  = offset[2 +: CH_W];

  assign unused_wr_data = ^wr_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic              sel;
    logic              data_wr;
    logic              status_wr;
    logic              ctrl_wr;
    logic              drops_wr;
    logic              flush;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [GPIO_W-1:0] head;
    logic              en_r;
    logic              irq_en_r;
    logic              ovf_r;
    logic [7:0]        drops_r;
    status_t           st;
    logic [DATA_W-1:0] rd_word;

    assign sel       = wr_en & hit & (ch_sel == CH_W'(c));
    assign data_wr   = sel & (reg_sel == 2'(OFF_DATA));
    assign status_wr = sel & (reg_sel == 2'(OFF_STATUS));
    assign ctrl_wr   = sel & (reg_sel == 2'(OFF_CTRL));
    assign drops_wr  = sel & (reg_sel == 2'(OFF_DROPS));
    assign flush     = ctrl_wr & wr_data[CTRL_FLUSH];

    assign pop  = gpio_valid[c] & gpio_ready[c];
    assign drop = data_wr & full & ~pop;

    sync_fifo #(
      .WIDTH (GPIO_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_wr),
      .data  (wr_data[GPIO_W-1:0]),
      .pop   (pop),
      .flush (flush),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
    );

    assign gpio_valid[c]                   = en_r & ~empty;
    assign gpio_data[c*GPIO_W +: GPIO_W]   = head;
    assign ovf_q[c]                        = ovf_r;
    assign irq_en_q[c]                     = irq_en_r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_r     <= 1'b1;
        irq_en_r <= 1'b0;
        ovf_r    <= 1'b0;
        drops_r  <= '0;
      end else begin
        if (ctrl_wr) begin
          en_r     <= wr_data[CTRL_EN];
          irq_en_r <= wr_data[CTRL_IRQ_EN];
        end
        if (status_wr) begin
          ovf_r <= 1'b0;
        end else if (drop) begin
          ovf_r <= 1'b1;
        end
        if (drops_wr) begin
          drops_r <= '0;
        end else if (drop && (drops_r != 8'hFF)) begin
          drops_r <= drops_r + 8'd1;
        end
      end
    end

    always_comb begin
      st       = '0;
      st.empty = empty;
      st.full  = full;
      st.ovf   = ovf_r;
      st.count = 8'(count);
    end

    // DATA is write-only and flush is an action bit, so both read back as zero.
    always_comb begin
      rd_word = '0;
      case (reg_sel)
        2'(OFF_STATUS): rd_word = DATA_W'(st);
        2'(OFF_CTRL): begin
          rd_word[CTRL_EN]     = en_r;
          rd_word[CTRL_IRQ_EN] = irq_en_r;
        end
        2'(OFF_DROPS): rd_word = DATA_W'(drops_r);
        default: rd_word = '0;
      endcase
    end

    assign ch_rd[c] = rd_word;
  end

  assign rd_data = hit ? ch_rd[ch_sel] : '0;
  assign irq     = |(ovf_q & irq_en_q);

endmodule

// File: tb/tb_gpio_stream_ctrl.sv
// Directed plus randomized bench for gpio_stream_ctrl, checked against a queue-based model.
module tb_gpio_stream_ctrl;

  localparam int          CHANNELS = 2;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] BASE     = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;
  logic [15:0] gpio_data;
  logic [1:0]  gpio_valid;
  logic [1:0]  gpio_ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq [CHANNELS][$];
  bit         m_en     [CHANNELS];
  bit         m_irq_en [CHANNELS];
  bit         m_ovf    [CHANNELS];
  int         m_drops  [CHANNELS];

  gpio_stream_ctrl #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .GPIO_W    (8),
    .CHANNELS  (CHANNELS),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .hit        (hit),
    .gpio_data  (gpio_data),
    .gpio_valid (gpio_valid),
    .gpio_ready (gpio_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int c = 0; c < CHANNELS; c++) begin
      mq[c].delete();
      m_en[c]     = 1'b1;
      m_irq_en[c] = 1'b0;
      m_ovf[c]    = 1'b0;
      m_drops[c]  = 0;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit inRange(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * CHANNELS);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    int c;
    int r;
    int n;
    if (!inRange(a)) return 32'd0;
    c = int'((a - BASE) / 4);
    r = int'((a - BASE) % 4);
    n = mq[c].size();
    case (r)
      1:       return 32'(n == 0) + 2 * 32'(n == DEPTH) + 4 * 32'(m_ovf[c]) + 256 * 32'(n);
      2:       return 32'(m_en[c]) + 2 * 32'(m_irq_en[c]);
      3:       return 32'(m_drops[c]);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one bus cycle, advance the model by the rules of one clock edge, return at the next negedge.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] rdy);
    bit pop [CHANNELS];
    int pre_size [CHANNELS];
    int c;
    int r;
    wr_en      = w;
    addr       = a;
    wr_data    = d;
    gpio_ready = rdy;
    for (int k = 0; k < CHANNELS; k++) begin
      pre_size[k] = mq[k].size();
      pop[k]      = m_en[k] && (pre_size[k] > 0) && rdy[k];
    end
    c = 0;
    r = -1;
    if (w && inRange(a)) begin
      c = int'((a - BASE) / 4);
      r = int'((a - BASE) % 4);
    end
    if (r == 2 && d[2]) pop[c] = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pop[k]) void'(mq[k].pop_front());
    end
    case (r)
      0: begin
        if (pre_size[c] < DEPTH || pop[c]) begin
          mq[c].push_back(d[7:0]);
        end else begin
          m_ovf[c] = 1'b1;
          if (m_drops[c] < 255) m_drops[c]++;
        end
      end
      1: m_ovf[c] = 1'b0;
      2: begin
        m_en[c]     = d[0];
        m_irq_en[c] = d[1];
        if (d[2]) mq[c].delete();
      end
      3: m_drops[c] = 0;
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] exp_data;
    logic [1:0]  exp_valid;
    logic        exp_irq;
    exp_data  = '0;
    exp_valid = '0;
    exp_irq   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mq[c].size() > 0) exp_data[c*8 +: 8] = mq[c][0];
      exp_valid[c] = m_en[c] && (mq[c].size() > 0);
      if (m_ovf[c] && m_irq_en[c]) exp_irq = 1'b1;
    end
    checkVal({tag, ".valid"}, 32'(gpio_valid), 32'(exp_valid));
    checkVal({tag, ".data"}, 32'(gpio_data), 32'(exp_data));
    checkVal({tag, ".irq"}, 32'(irq), 32'(exp_irq));
  endtask

  task automatic readCheck(input string tag, input logic [31:0] a);
    wr_en = 1'b0;
    addr  = a;
    #1;
    checkVal({tag, ".rd"}, rd_data, modelRead(a));
    checkVal({tag, ".hit"}, 32'(hit), 32'(inRange(a)));
  endtask

  initial begin
    logic [31:0] ra;
    rst        = 1'b1;
    wr_en      = 1'b0;
    addr       = '0;
    wr_data    = '0;
    gpio_ready = '0;
    modelReset();

    #1;
    checkVal("inreset.valid", 32'(gpio_valid), 32'd0);
    checkVal("inreset.data", 32'(gpio_data), 32'd0);
    checkVal("inreset.irq", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    readCheck("rst.status", BASE + 1);
    checkVal("rst.status_const", rd_data, 32'h0000_0001);
    readCheck("rst.ctrl", BASE + 2);
    readCheck("rst.miss", BASE - 1);
    checkOutput("rst");

    // Single entry, held stable while not ready, then popped
    applyStimulus(1'b1, BASE, 32'hFFFF_FFA5, 2'b00);
    checkOutput("t2.first");
    checkVal("t2.head", 32'(gpio_data[7:0]), 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
      checkOutput("t2.hold");
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b01);
    checkOutput("t2.pop");
    readCheck("t2.status", BASE + 1);

    // Overfill channel 0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, BASE, 32'h11 + 32'(i), 2'b00);
      checkOutput("t3.fill");
    end
    readCheck("t3.status", BASE + 1);
    checkVal("t3.status_const", rd_data, 32'h0000_0406);
    readCheck("t3.drops", BASE + 3);

    // Push into full FIFO while its head is popped
    applyStimulus(1'b1, BASE, 32'h99, 2'b01);
    checkOutput("t4.pushpop");
    readCheck("t4.status", BASE + 1);
    readCheck("t4.drops", BASE + 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b01);
      checkOutput("t4.drain");
    end

    // Channel 1 overflow with interrupt enabled, clear, flush
    applyStimulus(1'b1, BASE + 6, 32'h3, 2'b00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, BASE + 4, 32'h40 + 32'(i), 2'b00);
    end
    checkOutput("t5.ovf");
    checkVal("t5.irq_const", 32'(irq), 32'd1);
    readCheck("t5.status", BASE + 5);
    applyStimulus(1'b1, BASE + 5, 32'h0, 2'b00);
    checkOutput("t5.clr");
    checkVal("t5.irq_clr", 32'(irq), 32'd0);
    applyStimulus(1'b1, BASE + 6, 32'h7, 2'b10);
    checkOutput("t5.flush");
    readCheck("t5.status2", BASE + 5);
    readCheck("t5.ctrl", BASE + 6);

    // Drop counter saturation on channel 0
    applyStimulus(1'b1, BASE + 3, 32'h0, 2'b00);
    for (int i = 0; i < 264; i++) begin
      applyStimulus(1'b1, BASE, $urandom, 2'b00);
    end
    readCheck("sat.drops", BASE + 3);
    readCheck("sat.status", BASE + 1);
    applyStimulus(1'b1, BASE + 2, 32'h4, 2'b00);
    applyStimulus(1'b1, BASE + 1, 32'h0, 2'b00);
    checkOutput("sat.flush");
    applyStimulus(1'b1, BASE + 2, 32'h3, 2'b00);

    // Randomized traffic around the register window
    for (int i = 0; i < 400; i++) begin
      ra = BASE - 2 + 32'($urandom_range(0, 11));
      applyStimulus(1'($urandom_range(0, 9) < 6), ra, $urandom, 2'($urandom));
      checkOutput("rnd");
      ra = BASE - 2 + 32'($urandom_range(0, 11));
      readCheck("rnd", ra);
    end

    // Asynchronous reset while draining
    applyStimulus(1'b1, BASE + 2, 32'h5, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, BASE, 32'h60 + 32'(i), 2'b00);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b01);
    checkOutput("t6.pre");
    #2;
    rst = 1'b1;
    #1;
    checkVal("t6.async_valid", 32'(gpio_valid), 32'd0);
    checkVal("t6.async_data", 32'(gpio_data), 32'd0);
    checkVal("t6.async_irq", 32'(irq), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    readCheck("t6.status", BASE + 1);
    checkVal("t6.status_const", rd_data, 32'h0000_0001);
    readCheck("t6.ctrl", BASE + 2);
    checkOutput("t6.post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_stream_ctrl.md
Name: gpio_stream_ctrl

Overview:
- Memory-mapped, multi-channel GPIO output controller. It replaces the single 8-bit GPIO/GPIOEn strobe path of the memory controller.
- Each channel buffers processor stores in a FIFO and drains them to an external consumer over a valid/ready handshake.
- Per-channel control, status and drop-count registers are exposed. Reads are combinational so they fit the existing memory-stage read mux.

Parameters:
- ADDR_W, 32, width of the bus address (word addressed).
- DATA_W, 32, width of the bus write and read data.
- GPIO_W, 8, width of each channel's output data (must be ≤ DATA_W).
- CHANNELS, 2, number of independent output channels (1..8).
- DEPTH, 4, FIFO entries per channel (power of 2, ≥2).
- BASE_ADDR, 32'h0000_0400, word address of channel 0's register block.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  bus write strobe (memory stage).
- addr  in  ADDR_W  bus word address.
- wr_data  in  DATA_W  bus write data.
- rd_data  out  DATA_W  combinational read data; 0 when the address misses.
- hit  out  1  address falls in [BASE_ADDR, BASE_ADDR+4*CHANNELS).
- gpio_data  out  CHANNELS*GPIO_W  FIFO head per channel; channel c occupies bits [c*GPIO_W +: GPIO_W].
- gpio_valid  out  CHANNELS  head valid per channel.
- gpio_ready  in  CHANNELS  consumer accepts the head.
- irq  out  1  interrupt request level.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Register map per channel c, at offset BASE_ADDR+4c:
  - +0 DATA: write-only. A write pushes wr_data[GPIO_W-1:0].
  - +1 STATUS: read-only fields. Bit0 empty, bit1 full, bit2 ovf (sticky), bits[15:8] count (zero-extended). Any write to STATUS clears ovf.
  - +2 CTRL: bit0 en, bit1 irq_en, bit2 flush (write-1 action, always reads 0).
  - +3 DROPS: 8-bit saturating drop counter, zero-extended on read. Any write clears it.
  - Unused bits read 0.
- Reset state (asynchronous): all FIFOs empty; count=0; ovf=0; DROPS=0; en=1; irq_en=0. Outputs during reset: gpio_valid=0, gpio_data=0, irq=0.
- Output handshake:
  - gpio_valid[c] = en & !empty.
  - gpio_data shows the head, or 0 when empty.
  - Pop on the rising edge when valid & ready.
  - Data must stay stable while valid & !ready.
  - Clearing en holds the FIFO contents and drops valid the same cycle.
- Push:
  - A DATA write when !full, or when full with a pop in the same cycle, is accepted. Latency: the first entry is visible on gpio_data/gpio_valid the cycle after the write.
  - A DATA write when full with no pop is discarded: ovf←1, DROPS←min(DROPS+1, 255).
- Simultaneous push and pop: count unchanged; pointers both advance; wrap-around modulo DEPTH.
- Flush (CTRL write with bit2=1): pointers and count reset to 0 at the edge. en and irq_en take the written bits 0 and 1. A pop in the same cycle is void. ovf and DROPS are unaffected.
- Address decode: misses are ignored for writes and read as 0. Writes to different channels are independent; only one bus write per cycle.
- Interrupt: irq = OR over c of (ovf[c] & irq_en[c]), registered-state derived and combinational.
- count width is $clog2(DEPTH+1) and must reach DEPTH exactly.

Decomposition:
- Package gpio_stream_pkg holds:
  - register offset constants: OFF_DATA=0, OFF_STATUS=1, OFF_CTRL=2, OFF_DROPS=3;
  - STATUS and CTRL bit-index constants;
  - a status_t packed struct.
- One natural sub-module: sync_fifo, parametrised by WIDTH and DEPTH, with push, pop, flush, full, empty, count and head outputs. Instantiate it once per channel with a generate loop.
- Decode, register bank and read mux stay in the top module.

Test Plan:
1. After reset: read BASE+1 → 0x0000_0001 (empty). gpio_valid=0. irq=0.
2. Write 0xA5 to BASE+0 with ready=0. Next cycle gpio_valid[0]=1 and gpio_data[7:0]=0xA5. Hold 3 cycles stable, raise ready → gpio_valid drops; STATUS=0x0000_0001.
3. With DEPTH=4 and ready=0, write 0x11..0x15 to BASE+0:
   - STATUS → count=4, full=1, ovf=1.
   - BASE+3 reads 1.
   - Drain order is 0x11, 0x12, 0x13, 0x14.
4. With FIFO full and ready=1 in the same cycle as a DATA write of 0x99: count stays 4, DROPS unchanged, and 0x99 emerges last.
5. Overflow channel 1 (BASE+4) with irq_en=1 (CTRL write 0x3):
   - irq=1 and channel 0 is unaffected.
   - Writing BASE+5 clears ovf → irq=0.
   - Writing CTRL 0x7 empties channel 1 with en=1.
6. Assert rst mid-drain with 3 entries queued → gpio_valid=0 immediately (asynchronous). After release, STATUS=0x1 and en=1.
